// File: rtl/seq_recognizer_param_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_recognizer_param_pkg
// Purpose  : Shared constants and types for the parametrised sequence recognizer.
// Revision : 1.0  initial release
// ============================================================================
package seq_recognizer_param_pkg;

  localparam int         c_STATE_W  = 3;
  localparam int         c_MAX_N    = 8;
  localparam logic [5:0] c_DEF_PAT  = 6'b100111;

  // Per-edge action chosen by the control priority (pat_load over X_valid)
  typedef enum logic [1:0] {
    ACT_IDLE   = 2'd0,
    ACT_LOAD   = 2'd1,
    ACT_SAMPLE = 2'd2
  } act_t;

endpackage
`default_nettype wire

// File: rtl/seq_recognizer_param_fallback.sv
`default_nettype none
// ============================================================================
// Module   : seq_recognizer_param_fallback
// Purpose  : Combinational next-prefix search, full-match detect and pattern border.
// Revision : 1.0  initial release
// ============================================================================
module seq_recognizer_param_fallback
  import seq_recognizer_param_pkg::*;
#(
  parameter int W = 2,
  parameter int N = 3
) (
  input  logic [N*W-1:0]       P,
  input  logic [c_STATE_W-1:0] k,
  input  logic [W-1:0]         X,
  output logic [c_STATE_W-1:0] next_k,
  output logic                 full_match,
  output logic [c_STATE_W-1:0] border_len
);

  always_comb begin
    logic w_ok;
    w_ok       = 1'b0;
    next_k     = '0;
    full_match = 1'b0;
    border_len = '0;
    // Longest j such that P[0..j-1] is a suffix of (P[0..k-1], X); larger j wins
    for (int kk = 0; kk < N; kk++) begin
      if (k == c_STATE_W'(kk)) begin
        full_match = (kk == N-1) && (X == P[kk*W +: W]);
        for (int j = 1; j < N; j++) begin
          if (j <= kk + 1) begin
            w_ok = (X == P[(j-1)*W +: W]);
            for (int i = 0; i < j-1; i++) begin
              if (P[i*W +: W] != P[((kk + 1 - j + i + N) % N)*W +: W]) w_ok = 1'b0;
            end
            if (w_ok) next_k = c_STATE_W'(j);
          end
        end
      end
    end
    for (int b = 1; b < N; b++) begin
      w_ok = 1'b1;
      for (int i = 0; i < b; i++) begin
        if (P[i*W +: W] != P[(N - b + i)*W +: W]) w_ok = 1'b0;
      end
      if (w_ok) border_len = c_STATE_W'(b);
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_recognizer_param.sv
`default_nettype none
// ============================================================================
// Module   : seq_recognizer_param
// Purpose  : Mealy recognizer of a loadable N-symbol pattern, registered match
//            pulse and saturating match counter.
// Revision : 1.0  initial release
// ============================================================================
module seq_recognizer_param
  import seq_recognizer_param_pkg::*;
#(
  parameter int             W       = 2,
  parameter int             N       = 3,
  parameter int             CNT_W   = 8,
  parameter logic [N*W-1:0] DEF_PAT = c_DEF_PAT
) (
  input  logic                 Ck,
  input  logic                 reset_,
  input  logic [W-1:0]         X,
  input  logic                 X_valid,
  input  logic [N*W-1:0]       pat,
  input  logic                 pat_load,
  input  logic                 overlap,
  input  logic                 clr_cnt,
  output logic                 Z,
  output logic [CNT_W-1:0]     match_cnt,
  output logic [c_STATE_W-1:0] state_o
);

  logic [N*W-1:0]       r_pat, w_pat;
  logic [c_STATE_W-1:0] r_k, w_k;
  logic                 r_z, w_z;
  logic [CNT_W-1:0]     r_cnt, w_cnt;
  act_t                 w_act;
  logic [c_STATE_W-1:0] w_fb_k, w_border;
  logic                 w_full;

  seq_recognizer_param_fallback #(.W(W), .N(N)) u_fallback (
    .P          (r_pat),
    .k          (r_k),
    .X          (X),
    .next_k     (w_fb_k),
    .full_match (w_full),
    .border_len (w_border)
  );

  always_ff @(posedge Ck or negedge reset_) begin
    if (!reset_) begin
      r_pat <= DEF_PAT;
      r_k   <= '0;
      r_z   <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_pat <= w_pat;
      r_k   <= w_k;
      r_z   <= w_z;
      r_cnt <= w_cnt;
    end
  end

  always_comb begin
    w_act = ACT_IDLE;
    if (pat_load)     w_act = ACT_LOAD;
    else if (X_valid) w_act = ACT_SAMPLE;
    w_pat = r_pat;
    w_k   = r_k;
    w_z   = 1'b0;
    w_cnt = r_cnt;
    case (w_act)
      ACT_LOAD: begin
        w_pat = pat;
        w_k   = '0;
      end
      ACT_SAMPLE: begin
        if (w_full) begin
          w_z = 1'b1;
          w_k = overlap ? w_border : '0;
          if (r_cnt != {CNT_W{1'b1}}) w_cnt = r_cnt + 1'b1;
        end else begin
          w_k = w_fb_k;
        end
      end
      default: ;
    endcase
    // Clear dominates a coincident increment; Z is unaffected
    if (clr_cnt) w_cnt = '0;
  end

  assign Z         = r_z;
  assign match_cnt = r_cnt;
  assign state_o   = r_k;

endmodule
`default_nettype wire

// File: tb/tb_seq_recognizer_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_recognizer_param
// Purpose  : Self-checking bench: history-based reference model plus directed scenarios.
// Revision : 1.0  initial release
// ============================================================================
module tb_seq_recognizer_param;

  localparam int W = 2;
  localparam int N = 3;

  logic         ck;
  logic         rst_n;
  logic [W-1:0] x;
  logic         xv;
  logic [N*W-1:0] pat;
  logic         pl;
  logic         ov;
  logic         clr;
  logic         z, z2;
  logic [7:0]   cnt;
  logic [1:0]   cnt2;
  logic [2:0]   st, st2;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  int mp[N];
  int hist[$];
  int m_k, m_cnt, m_cnt2;
  bit m_z;

  seq_recognizer_param #(.W(W), .N(N), .CNT_W(8)) dut (
    .Ck(ck), .reset_(rst_n), .X(x), .X_valid(xv), .pat(pat), .pat_load(pl),
    .overlap(ov), .clr_cnt(clr), .Z(z), .match_cnt(cnt), .state_o(st)
  );

  seq_recognizer_param #(.W(W), .N(N), .CNT_W(2)) dut2 (
    .Ck(ck), .reset_(rst_n), .X(x), .X_valid(xv), .pat(pat), .pat_load(pl),
    .overlap(ov), .clr_cnt(clr), .Z(z2), .match_cnt(cnt2), .state_o(st2)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  function automatic void load_model_pat(input logic [N*W-1:0] p);
    for (int i = 0; i < N; i++) mp[i] = int'(p[i*W +: W]);
  endfunction

  // Longest j<N such that the last j sampled symbols spell the pattern prefix
  function automatic int suffix_len();
    int best;
    bit ok;
    best = 0;
    for (int j = 1; j < N; j++) begin
      if (j <= hist.size()) begin
        ok = 1'b1;
        for (int i = 0; i < j; i++)
          if (hist[hist.size() - j + i] != mp[i]) ok = 1'b0;
        if (ok) best = j;
      end
    end
    return best;
  endfunction

  function automatic bit full_hit();
    bit ok;
    ok = (hist.size() == N);
    if (ok) for (int i = 0; i < N; i++) if (hist[i] != mp[i]) ok = 1'b0;
    return ok;
  endfunction

  always @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      load_model_pat(6'b100111);
      hist.delete();
      m_k = 0; m_z = 1'b0; m_cnt = 0; m_cnt2 = 0;
    end else begin
      m_z = 1'b0;
      if (pl) begin
        load_model_pat(pat);
        hist.delete();
      end else if (xv) begin
        hist.push_back(int'(x));
        if (hist.size() > N) void'(hist.pop_front());
        if (full_hit()) begin
          m_z = 1'b1;
          if (m_cnt < 255) m_cnt++;
          if (m_cnt2 < 3) m_cnt2++;
          if (!ov) hist.delete();
        end
      end
      if (clr) begin m_cnt = 0; m_cnt2 = 0; end
      m_k = suffix_len();
    end
  end

  always @(negedge ck) begin
    if (rst_n === 1'b1) begin
      chk("z",     int'(z),    int'(m_z));
      chk("z2",    int'(z2),   int'(m_z));
      chk("state", int'(st),   m_k);
      chk("cnt",   int'(cnt),  m_cnt);
      chk("cnt2",  int'(cnt2), m_cnt2);
    end
  end

  task automatic step(input int xs, input bit v);
    x  = W'(xs);
    xv = v;
    @(negedge ck);
    pl  = 1'b0;
    clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; x = '0; xv = 1'b0; pl = 1'b0; clr = 1'b0; ov = 1'b1; pat = '0;
    repeat (2) @(negedge ck);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    @(negedge ck);
    do_reset();
    chk("reset_z", int'(z), 0);
    chk("reset_state", int'(st), 0);
    chk("reset_cnt", int'(cnt), 0);

    // Basic detection
    step(3, 1); chk("t1_k1", int'(st), 1);
    step(1, 1); chk("t1_k2", int'(st), 2);
    step(2, 1); chk("t1_z", int'(z), 1); chk("t1_cnt", int'(cnt), 1);
    step(0, 0); chk("t1_z_drop", int'(z), 0);

    // Fallback on repeated first symbol
    do_reset();
    step(3, 1); step(3, 1); chk("t2_stay1", int'(st), 1);
    step(1, 1); chk("t2_k2", int'(st), 2);
    step(2, 1); chk("t2_z", int'(z), 1); chk("t2_cnt", int'(cnt), 1);

    // All-ones pattern, overlap then non-overlap
    do_reset();
    pl = 1'b1; pat = 6'b111111; step(0, 0);
    ov = 1'b1;
    step(3, 1); step(3, 1); chk("t3_z_pre", int'(z), 0);
    step(3, 1); chk("t3_z1", int'(z), 1); chk("t3_k", int'(st), 2);
    step(3, 1); chk("t3_z2", int'(z), 1);
    step(3, 1); chk("t3_z3", int'(z), 1); chk("t3_cnt", int'(cnt), 3);
    pl = 1'b1; clr = 1'b1; step(0, 0); chk("t3_clr", int'(cnt), 0);
    ov = 1'b0;
    step(3, 1); step(3, 1);
    step(3, 1); chk("t3n_z", int'(z), 1); chk("t3n_k", int'(st), 0);
    step(3, 1); chk("t3n_z_low", int'(z), 0);
    step(3, 1); chk("t3n_cnt", int'(cnt), 1);

    // Invalid cycles hold state
    do_reset();
    step(3, 1); step(1, 1);
    repeat (3) begin step(2, 0); chk("t4_hold", int'(st), 2); end
    step(2, 1); chk("t4_z", int'(z), 1); chk("t4_cnt", int'(cnt), 1);

    // Saturation on the narrow counter, clear beats coincident match
    do_reset();
    repeat (5) begin step(3, 1); step(1, 1); step(2, 1); end
    chk("t5_cnt8", int'(cnt), 5); chk("t5_cnt2_sat", int'(cnt2), 3);
    step(3, 1); step(1, 1);
    clr = 1'b1; step(2, 1);
    chk("t5_clr_z", int'(z), 1); chk("t5_clr_cnt", int'(cnt), 0); chk("t5_clr_cnt2", int'(cnt2), 0);

    // Asynchronous reset mid-cycle
    do_reset();
    step(3, 1); step(1, 1); step(2, 1); step(3, 1); step(1, 1);
    chk("t6_pre_k", int'(st), 2); chk("t6_pre_cnt", int'(cnt), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_k", int'(st), 0); chk("t6_async_cnt", int'(cnt), 0); chk("t6_async_z", int'(z), 0);
    @(negedge ck); rst_n = 1'b1;

    // pat_load wins over a completing symbol
    step(3, 1); step(1, 1);
    pl = 1'b1; pat = 6'b000110; step(2, 1);
    chk("t6_load_z", int'(z), 0); chk("t6_load_k", int'(st), 0); chk("t6_load_cnt", int'(cnt), 0);
    step(2, 1); step(1, 1); step(0, 1);
    chk("t6_newpat_z", int'(z), 1);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      ov  = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 49) == 0) begin
        pl = 1'b1;
        case ($urandom_range(0, 3))
          0:       pat = 6'b111111;
          1:       pat = 6'b010101;
          2:       pat = 6'b100111;
          default: pat = 6'($urandom);
        endcase
      end
      step($urandom_range(0, 3), $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
